// File: rtl/lift_step_pipe_pkg.sv
// Shared types and helpers for the LeGall 5/3 lifting-step pipeline.
// Data fields are held at a fixed maximum width so one record type serves every W up to LIFT_MW.
package lift_pkg;

    localparam int LIFT_MW = 32;
    localparam int LIFT_FW = LIFT_MW + 2;

    localparam logic MODE_PRED = 1'b1;
    localparam logic MODE_UPD  = 1'b0;
    localparam logic DIR_FWD   = 1'b1;
    localparam logic DIR_INV   = 1'b0;

    typedef logic signed [LIFT_FW-1:0] lift_full_t;

    typedef struct packed {
        logic                      valid;
        logic signed [LIFT_MW-1:0] sam;
        logic signed [LIFT_MW:0]   sum1;
        logic                      even_odd;
        logic                      fwd_inv;
    } stage_rec_t;

    // Clamp a wide result into the signed w-bit range.
    function automatic lift_full_t sat_w(input lift_full_t value, input int w);
        lift_full_t hi;
        lift_full_t lo;
        hi = (lift_full_t'(1) <<< (w - 1)) - lift_full_t'(1);
        lo = -hi - lift_full_t'(1);
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/lift_step_pipe_if.sv
// Sample-in / result-out stream bundle of the lifting-step unit.
interface lift_step_pipe_if #(
    parameter int W     = 16,
    parameter int CNT_W = 16
);
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] left_s;
    logic signed [W-1:0] right_s;
    logic signed [W-1:0] sam_s;
    logic                even_odd_s;
    logic                fwd_inv_s;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] res_s;
    logic                sat_flag;
    logic [CNT_W-1:0]    sample_cnt;

    modport master (
        output in_valid, left_s, right_s, sam_s, even_odd_s, fwd_inv_s, out_ready,
        input  in_ready, out_valid, res_s, sat_flag, sample_cnt
    );

    modport slave (
        input  in_valid, left_s, right_s, sam_s, even_odd_s, fwd_inv_s, out_ready,
        output in_ready, out_valid, res_s, sat_flag, sample_cnt
    );
endinterface

// File: rtl/lift_step_pipe_arith.sv
// Combinational predict/update arithmetic: exact wide result plus W-range overflow flag.
module lift_arith
    import lift_pkg::*;
#(
    parameter int W = 16
) (
    input  logic signed [LIFT_MW:0]   sum1,
    input  logic signed [LIFT_MW-1:0] sam,
    input  logic                      even_odd,
    input  logic                      fwd_inv,
    output lift_full_t                full,
    output logic                      ovf
);
    localparam lift_full_t HI = (lift_full_t'(1) <<< (W - 1)) - lift_full_t'(1);
    localparam lift_full_t LO = -HI - lift_full_t'(1);

    lift_full_t sum_x;
    lift_full_t delta;

    always_comb begin
        sum_x = lift_full_t'(sum1);
        if (even_odd == MODE_PRED) begin
            delta = sum_x >>> 1;
        end else begin
            delta = (sum_x + lift_full_t'(2)) >>> 2;
        end
        // Forward predict and inverse update subtract; the other two add.
        if ((even_odd == MODE_PRED) == (fwd_inv == DIR_FWD)) begin
            full = lift_full_t'(sam) - delta;
        end else begin
            full = lift_full_t'(sam) + delta;
        end
        ovf = (full > HI) || (full < LO);
    end
endmodule

// File: rtl/lift_step_pipe.sv
// Two-stage pipelined LeGall 5/3 lifting step with valid/ready backpressure.
// W may range up to lift_pkg::LIFT_MW.
module lift_step_pipe
    import lift_pkg::*;
#(
    parameter int W     = 16,
    parameter int SAT   = 1,
    parameter int CNT_W = 16
) (
    input logic         clk_fast,
    input logic         rst,
    lift_step_pipe_if.slave bus
);
    stage_rec_t          st1_q, st1_d;
    logic                v2_q, v2_d;
    logic signed [W-1:0] res_q, res_d;
    logic                sat_q, sat_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                adv;
    logic                in_xfer;
    lift_full_t          full;
    logic                ovf;
    logic signed [W-1:0] res_w;

    lift_arith #(.W(W)) u_arith (
        .sum1     (st1_q.sum1),
        .sam      (st1_q.sam),
        .even_odd (st1_q.even_odd),
        .fwd_inv  (st1_q.fwd_inv),
        .full     (full),
        .ovf      (ovf)
    );

    assign res_w = W'((SAT != 0) ? sat_w(full, W) : full);

    always_comb begin
        adv     = !v2_q || bus.out_ready;
        in_xfer = bus.in_valid && adv;
        st1_d   = st1_q;
        v2_d    = v2_q;
        res_d   = res_q;
        sat_d   = sat_q;
        cnt_d   = cnt_q + CNT_W'(in_xfer);
        // Whole pipe moves as one; a stalled output freezes both stages.
        if (adv) begin
            st1_d.valid    = in_xfer;
            st1_d.sam      = LIFT_MW'(bus.sam_s);
            st1_d.sum1     = (LIFT_MW + 1)'(bus.left_s) + (LIFT_MW + 1)'(bus.right_s);
            st1_d.even_odd = bus.even_odd_s;
            st1_d.fwd_inv  = bus.fwd_inv_s;
            v2_d           = st1_q.valid;
            if (st1_q.valid) begin
                res_d = res_w;
                sat_d = sat_q | ovf;
            end
        end
    end

    always_ff @(posedge clk_fast) begin
        if (rst) begin
            st1_q <= '0;
            v2_q  <= 1'b0;
            res_q <= '0;
            sat_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            st1_q <= st1_d;
            v2_q  <= v2_d;
            res_q <= res_d;
            sat_q <= sat_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.in_ready   = adv;
    assign bus.out_valid  = v2_q;
    assign bus.res_s      = res_q;
    assign bus.sat_flag   = sat_q;
    assign bus.sample_cnt = cnt_q;
endmodule

// File: tb/tb_lift_step_pipe.sv
// Self-checking bench for lift_step_pipe: vector table, stall/reset sequences,
// randomized scoreboard against an arithmetic model, and a 5/3 round trip.
module tb_lift_step_pipe;
    localparam int W = 16;

    logic clk_fast = 1'b0;
    logic rst;
    always #5 clk_fast = ~clk_fast;

    lift_step_pipe_if #(.W(W), .CNT_W(16)) bus0 ();
    lift_step_pipe_if #(.W(W), .CNT_W(4))  bus1 ();

    lift_step_pipe #(.W(W), .SAT(1), .CNT_W(16)) dut (
        .clk_fast (clk_fast), .rst (rst), .bus (bus0.slave)
    );
    lift_step_pipe #(.W(W), .SAT(0), .CNT_W(4)) dut_wrap (
        .clk_fast (clk_fast), .rst (rst), .bus (bus1.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int  exp_q[$];
    int  got_q[$];
    bit  sb_en = 1'b0;
    bit  stalled = 1'b0;
    logic signed [W-1:0] hold_res;

    int b_l[128], b_r[128], b_s[128];
    bit b_eo[128], b_fi[128];

    typedef struct {
        int l; int r; int s; bit eo; bit fi; int exp_res; bit exp_sat;
    } vec_t;
    vec_t tbl[9];

    task automatic check(input string name, input logic signed [63:0] act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: floor division and the lifting rules as plain integer maths.
    function automatic int floordiv(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    function automatic int ref_res(input int l, input int r, input int s,
                                   input bit eo, input bit fi, input bit sat);
        int sum, delta, full, hi, lo, m;
        sum   = l + r;
        delta = eo ? floordiv(sum, 2) : floordiv(sum + 2, 4);
        full  = (eo == fi) ? s - delta : s + delta;
        hi    = (1 << (W - 1)) - 1;
        lo    = -(1 << (W - 1));
        if (sat) begin
            if (full > hi) full = hi;
            if (full < lo) full = lo;
        end else begin
            m = (full - lo) % (1 << W);
            if (m < 0) m += (1 << W);
            full = m + lo;
        end
        return full;
    endfunction

    task automatic cyc();
        @(posedge clk_fast);
        #1;
    endtask

    task automatic drive0(input bit v, input int l, input int r, input int s,
                          input bit eo, input bit fi);
        bus0.in_valid   = v;
        bus0.left_s     = W'(l);
        bus0.right_s    = W'(r);
        bus0.sam_s      = W'(s);
        bus0.even_odd_s = eo;
        bus0.fwd_inv_s  = fi;
    endtask

    task automatic drive1(input bit v, input int l, input int r, input int s,
                          input bit eo, input bit fi);
        bus1.in_valid   = v;
        bus1.left_s     = W'(l);
        bus1.right_s    = W'(r);
        bus1.sam_s      = W'(s);
        bus1.even_odd_s = eo;
        bus1.fwd_inv_s  = fi;
    endtask

    // One clock of the bus0 stream: scoreboard the output side, record the input side.
    task automatic tick();
        int e;
        if (sb_en) begin
            if (stalled) begin
                check("stall_hold_res", bus0.res_s, hold_res);
                check("stall_hold_valid", bus0.out_valid, 1);
            end
            if (bus0.out_valid && !bus0.out_ready) check("stall_in_ready", bus0.in_ready, 0);
            if (bus0.out_valid && bus0.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_output", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    $display("[TB] out #%0d res=%0d exp=%0d", got_q.size(), bus0.res_s, e);
                    check("stream_res", bus0.res_s, e);
                    got_q.push_back(int'(bus0.res_s));
                end
            end
            stalled  = bus0.out_valid && !bus0.out_ready;
            hold_res = bus0.res_s;
            if (bus0.in_valid && bus0.in_ready)
                exp_q.push_back(ref_res(int'(bus0.left_s), int'(bus0.right_s), int'(bus0.sam_s),
                                        bus0.even_odd_s, bus0.fwd_inv_s, 1'b1));
        end
        cyc();
    endtask

    // rmode: 0 random valid/ready, 1 always ready, 2 ready low for batch cycles 3..7
    task automatic run_batch(input int n, input int rmode);
        int sent = 0;
        int c = 0;
        bit acc;
        got_q.delete();
        exp_q.delete();
        stalled = 1'b0;
        sb_en   = 1'b1;
        while (got_q.size() < n && c < 4000) begin
            if (sent < n)
                drive0((rmode != 0) || ($urandom_range(0, 3) != 0),
                       b_l[sent], b_r[sent], b_s[sent], b_eo[sent], b_fi[sent]);
            else
                bus0.in_valid = 1'b0;
            case (rmode)
                0:       bus0.out_ready = ($urandom_range(0, 2) != 0);
                2:       bus0.out_ready = !(c >= 3 && c <= 7);
                default: bus0.out_ready = 1'b1;
            endcase
            #1;
            acc = bus0.in_valid && bus0.in_ready;
            tick();
            if (acc) sent++;
            c++;
        end
        check("batch_delivered", got_q.size(), n);
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        repeat (3) tick();
        sb_en = 1'b0;
    endtask

    int x[64], d[32], s[32], xe[32];

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{10, 20, 100, 1'b1, 1'b1, 85, 1'b0};
        tbl[1] = '{-3, 5, 7, 1'b0, 1'b1, 8, 1'b0};
        tbl[2] = '{10, 20, 85, 1'b1, 1'b0, 100, 1'b0};
        tbl[3] = '{-1, 0, 0, 1'b1, 1'b1, 1, 1'b0};
        tbl[4] = '{0, -3, 0, 1'b0, 1'b0, 1, 1'b0};
        tbl[5] = '{32767, 32767, 32767, 1'b0, 1'b1, 32767, 1'b1};
        tbl[6] = '{-32768, -32768, -32768, 1'b1, 1'b0, -32768, 1'b1};
        tbl[7] = '{-32768, -32768, 32767, 1'b1, 1'b1, 32767, 1'b1};
        tbl[8] = '{100, -50, -7, 1'b0, 1'b0, -20, 1'b1};

        rst = 1'b1;
        drive0(0, 0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0, 0);
        bus0.out_ready = 1'b1;
        bus1.out_ready = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        check("rst_out_valid", bus0.out_valid, 0);
        check("rst_res", bus0.res_s, 0);
        check("rst_sat", bus0.sat_flag, 0);
        check("rst_cnt", bus0.sample_cnt, 0);
        check("rst_in_ready", bus0.in_ready, 1);

        // Isolated vectors: latency of two edges, value and sticky flag.
        for (int i = 0; i < 9; i++) begin
            drive0(1, tbl[i].l, tbl[i].r, tbl[i].s, tbl[i].eo, tbl[i].fi);
            #1;
            check("vec_in_ready", bus0.in_ready, 1);
            cyc();
            bus0.in_valid = 1'b0;
            check("vec_early_valid", bus0.out_valid, 0);
            if (i == 0) check("vec_cnt_first", bus0.sample_cnt, 1);
            cyc();
            $display("[TB] vec %0d res=%0d exp=%0d sat=%0d", i, bus0.res_s, tbl[i].exp_res, bus0.sat_flag);
            check("vec_valid", bus0.out_valid, 1);
            check("vec_res", bus0.res_s, tbl[i].exp_res);
            check("vec_sat", bus0.sat_flag, tbl[i].exp_sat);
            cyc();
            check("vec_drain", bus0.out_valid, 0);
        end

        // Back-to-back forward update then inverse predict.
        drive0(1, -3, 5, 7, 0, 1);
        cyc();
        drive0(1, 10, 20, 85, 1, 0);
        cyc();
        bus0.in_valid = 1'b0;
        check("b2b_valid_1", bus0.out_valid, 1);
        check("b2b_res_1", bus0.res_s, 8);
        cyc();
        check("b2b_valid_2", bus0.out_valid, 1);
        check("b2b_res_2", bus0.res_s, 100);
        cyc();
        check("b2b_drain", bus0.out_valid, 0);

        repeat (10) cyc();
        check("sat_sticky_idle", bus0.sat_flag, 1);

        // Wrap mode and 4-bit counter on the second instance.
        check("wrap_sat_init", bus1.sat_flag, 0);
        drive1(1, 32767, 32767, 32767, 0, 1);
        cyc();
        bus1.in_valid = 1'b0;
        cyc();
        check("wrap_valid", bus1.out_valid, 1);
        check("wrap_res", bus1.res_s, -16385);
        check("wrap_sat", bus1.sat_flag, 1);
        check("wrap_cnt_1", bus1.sample_cnt, 1);
        for (int i = 0; i < 16; i++) begin
            drive1(1, i, -i, 3 * i, i[0], i[1]);
            #1;
            check("cntwrap_in_ready", bus1.in_ready, 1);
            cyc();
        end
        bus1.in_valid = 1'b0;
        check("cntwrap_cnt", bus1.sample_cnt, 1);

        // Backpressure: 8 samples, ready held low mid-stream.
        for (int i = 0; i < 8; i++) begin
            b_l[i] = 100 * i; b_r[i] = -37 * i; b_s[i] = 1000 - 11 * i;
            b_eo[i] = i[0]; b_fi[i] = i[1];
        end
        run_batch(8, 2);

        // Random full-range stream, random handshakes.
        for (int i = 0; i < 100; i++) begin
            b_l[i]  = int'($urandom_range(0, 65535)) - 32768;
            b_r[i]  = int'($urandom_range(0, 65535)) - 32768;
            b_s[i]  = int'($urandom_range(0, 65535)) - 32768;
            b_eo[i] = 1'($urandom_range(0, 1));
            b_fi[i] = 1'($urandom_range(0, 1));
        end
        run_batch(100, 0);

        // 5/3 forward then inverse on 64 samples, symmetric edge extension.
        for (int i = 0; i < 64; i++) x[i] = int'($urandom_range(0, 4000)) - 2000;
        for (int i = 0; i < 32; i++) begin
            b_l[i] = x[2 * i]; b_r[i] = (i < 31) ? x[2 * i + 2] : x[62];
            b_s[i] = x[2 * i + 1]; b_eo[i] = 1'b1; b_fi[i] = 1'b1;
        end
        run_batch(32, 0);
        for (int i = 0; i < 32; i++) d[i] = (i < got_q.size()) ? got_q[i] : 0;
        for (int i = 0; i < 32; i++) begin
            b_l[i] = d[(i > 0) ? i - 1 : 0]; b_r[i] = d[i];
            b_s[i] = x[2 * i]; b_eo[i] = 1'b0; b_fi[i] = 1'b1;
        end
        run_batch(32, 0);
        for (int i = 0; i < 32; i++) s[i] = (i < got_q.size()) ? got_q[i] : 0;
        for (int i = 0; i < 32; i++) begin
            b_l[i] = d[(i > 0) ? i - 1 : 0]; b_r[i] = d[i];
            b_s[i] = s[i]; b_eo[i] = 1'b0; b_fi[i] = 1'b0;
        end
        run_batch(32, 1);
        for (int i = 0; i < 32; i++) xe[i] = (i < got_q.size()) ? got_q[i] : 0;
        for (int i = 0; i < 32; i++) begin
            b_l[i] = xe[i]; b_r[i] = (i < 31) ? xe[i + 1] : xe[31];
            b_s[i] = d[i]; b_eo[i] = 1'b1; b_fi[i] = 1'b0;
        end
        run_batch(32, 0);
        for (int i = 0; i < 32; i++) begin
            check("roundtrip_even", xe[i], x[2 * i]);
            check("roundtrip_odd", (i < got_q.size()) ? got_q[i] : 0, x[2 * i + 1]);
        end

        // Reset with two samples in flight.
        bus0.out_ready = 1'b1;
        drive0(1, 32767, 32767, 32767, 0, 1);
        cyc();
        drive0(1, 10, 20, 100, 1, 1);
        cyc();
        bus0.in_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("midrst_out_valid", bus0.out_valid, 0);
        check("midrst_sat", bus0.sat_flag, 0);
        check("midrst_cnt", bus0.sample_cnt, 0);
        check("midrst_in_ready", bus0.in_ready, 1);
        check("midrst_res", bus0.res_s, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("midrst_no_stale", bus0.out_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
